// File: rtl/apb_spi_norflash_ctrl_pkg.sv
// Shared constants and frame state encoding for the APB to word-parallel NOR flash bridge.
package apb_spi_norflash_ctrl_pkg;

  localparam int LINEWIDE = 32;
  localparam int ADDR_W   = 24;
  localparam int CMD_W    = 8;

  localparam logic [CMD_W-1:0] CMD_READ  = 8'h01;
  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD_LO = 3'd1,
    CMD_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4
  } frame_state_e;

endpackage

// File: rtl/apb_spi_norflash_ctrl_spi_frame_engine.sv
// Two-beat flash frame sequencer: owns the frame FSM and drives s_clk, s_css and s_mosi.
module spi_frame_engine
  import apb_spi_norflash_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                write_i,
  input  logic [LINEWIDE-1:0] cmd_word_i,
  input  logic [LINEWIDE-1:0] data_word_i,
  output logic                busy_o,
  output logic                capture_o,
  output logic                s_clk_o,
  output logic                s_css_o,
  output logic [LINEWIDE-1:0] s_mosi_o
);

  frame_state_e        state_q, state_d;
  logic                sclk_q, sclk_d;
  logic                css_q, css_d;
  logic [LINEWIDE-1:0] mosi_q, mosi_d;

  // Next-state and pin values for each phase of the frame.
  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    css_d   = css_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          css_d   = 1'b0;
          mosi_d  = cmd_word_i;
          state_d = CMD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      CMD_LO: begin
        sclk_d  = 1'b1;
        state_d = CMD_HI;
      end
      CMD_HI: begin
        sclk_d  = 1'b0;
        mosi_d  = data_word_i;
        state_d = DAT_LO;
      end
      DAT_LO: begin
        sclk_d  = 1'b1;
        state_d = DAT_HI;
      end
      DAT_HI: begin
        sclk_d  = 1'b0;
        css_d   = 1'b1;
        mosi_d  = {LINEWIDE{1'b0}};
        state_d = IDLE;
      end
      default: begin
        sclk_d  = 1'b0;
        css_d   = 1'b1;
        mosi_d  = {LINEWIDE{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // Frame state and pin registers; reset leaves the flash deselected.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      css_q   <= 1'b1;
      mosi_q  <= {LINEWIDE{1'b0}};
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      css_q   <= css_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign capture_o = (state_q == DAT_HI) && !write_i;
  assign s_clk_o   = sclk_q;
  assign s_css_o   = css_q;
  assign s_mosi_o  = mosi_q;

endmodule

// File: rtl/apb_spi_norflash_ctrl.sv
// APB slave front end: decodes zero-wait accesses, latches the request and holds the read result.
module apb_spi_norflash_ctrl
  import apb_spi_norflash_ctrl_pkg::*;
(
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic [LINEWIDE-1:0] p_addr,
  input  logic                p_write,
  input  logic                p_sel_x,
  input  logic                p_enable,
  input  logic [LINEWIDE-1:0] p_wdata,
  output logic [LINEWIDE-1:0] p_rdata,
  output logic [LINEWIDE-1:0] s_mosi,
  input  logic [LINEWIDE-1:0] s_miso,
  output logic                s_clk,
  output logic                s_css
);

  logic                write_q, write_d;
  logic [LINEWIDE-1:0] wdata_q, wdata_d;
  logic [LINEWIDE-1:0] rdata_q, rdata_d;
  logic                busy_s, capture_s, accept_s;
  logic [LINEWIDE-1:0] cmd_word_s, data_word_s;
  logic                unused_addr_s;

  // Access-phase edges arriving while a frame is in flight are dropped.
  assign accept_s      = p_sel_x && p_enable && !busy_s;
  assign cmd_word_s    = {p_addr[ADDR_W-1:0], (p_write ? CMD_WRITE : CMD_READ)};
  assign data_word_s   = write_q ? wdata_q : {LINEWIDE{1'b0}};
  assign unused_addr_s = ^p_addr[LINEWIDE-1:ADDR_W];

  // Request latch on accept and read capture at the end of a read frame.
  always_comb begin
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept_s) begin
      write_d = p_write;
      wdata_d = p_wdata;
    end else begin
      write_d = write_q;
      wdata_d = wdata_q;
    end
    if (capture_s) begin
      rdata_d = s_miso;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Request and read-data registers.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      write_q <= 1'b0;
      wdata_q <= {LINEWIDE{1'b0}};
      rdata_q <= {LINEWIDE{1'b0}};
    end else begin
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  spi_frame_engine u_engine (
    .clk_i       (p_clk),
    .rst_i       (p_rst),
    .start_i     (accept_s),
    .write_i     (write_q),
    .cmd_word_i  (cmd_word_s),
    .data_word_i (data_word_s),
    .busy_o      (busy_s),
    .capture_o   (capture_s),
    .s_clk_o     (s_clk),
    .s_css_o     (s_css),
    .s_mosi_o    (s_mosi)
  );

  assign p_rdata = rdata_q;

endmodule

// File: tb/tb_apb_spi_norflash_ctrl.sv
// Randomized bench: APB accesses against a flash slave model and a word-level reference memory.
module tb_apb_spi_norflash_ctrl;

  logic        p_clk = 1'b0;
  logic        p_rst;
  logic [31:0] p_addr;
  logic        p_write;
  logic        p_sel_x;
  logic        p_enable;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic [31:0] s_mosi;
  logic [31:0] s_miso = 32'h0;
  logic        s_clk;
  logic        s_css;

  int checks = 0;
  int errors = 0;

  // Flash device contents and the bench's own expectation of them.
  logic [31:0] flash_mem [logic [23:0]];
  logic [31:0] ref_mem [logic [23:0]];
  logic [31:0] ref_rdata = 32'h0;
  logic [31:0] fl_cmd = 32'h0;
  int          beat = 0;

  apb_spi_norflash_ctrl dut (
    .p_clk    (p_clk),
    .p_rst    (p_rst),
    .p_addr   (p_addr),
    .p_write  (p_write),
    .p_sel_x  (p_sel_x),
    .p_enable (p_enable),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .s_mosi   (s_mosi),
    .s_miso   (s_miso),
    .s_clk    (s_clk),
    .s_css    (s_css)
  );

  always #5 p_clk = ~p_clk;

  // Flash slave: beat 0 carries {addr, cmd}; beat 1 stores write data, reads are served from beat 0 on.
  always @(posedge s_clk or posedge s_css) begin
    if (s_css === 1'b1) begin
      beat = 0;
    end else if (beat == 0) begin
      fl_cmd = s_mosi;
      beat = 1;
      if (fl_cmd[7:0] == 8'h01)
        s_miso = flash_mem.exists(fl_cmd[31:8]) ? flash_mem[fl_cmd[31:8]] : 32'h0;
      else
        s_miso = $urandom;
    end else begin
      if (fl_cmd[7:0] == 8'h02) flash_mem[fl_cmd[31:8]] = s_mosi;
      beat = 2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB access plus a cycle-by-cycle check of the resulting flash frame.
  task automatic apb_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input bit poke);
    logic [31:0] cmd_w, dat_w, old_rd;
    logic [23:0] a;
    a      = addr[23:0];
    cmd_w  = {a, (wr ? 8'h02 : 8'h01)};
    dat_w  = wr ? wd : 32'h0;
    old_rd = ref_rdata;
    if (wr) ref_mem[a] = wd;
    else    ref_rdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0;

    @(negedge p_clk);
    p_sel_x = 1'b1; p_enable = 1'b0; p_write = wr; p_addr = addr; p_wdata = wd;
    @(negedge p_clk);
    p_enable = 1'b1;
    chk("rdata_access_phase", p_rdata, old_rd);
    @(negedge p_clk);
    p_sel_x = 1'b0; p_enable = 1'b0;
    chk("t0_css", {31'h0, s_css}, 32'h0);
    chk("t0_sclk", {31'h0, s_clk}, 32'h0);
    chk("t0_mosi", s_mosi, cmd_w);
    @(negedge p_clk);
    chk("beat0_sclk", {31'h0, s_clk}, 32'h1);
    chk("beat0_css", {31'h0, s_css}, 32'h0);
    chk("beat0_mosi", s_mosi, cmd_w);
    if (poke) begin
      p_sel_x = 1'b1; p_enable = 1'b1; p_write = ~wr; p_addr = ~addr; p_wdata = ~wd;
    end
    @(negedge p_clk);
    p_sel_x = 1'b0; p_enable = 1'b0;
    chk("t2_sclk", {31'h0, s_clk}, 32'h0);
    chk("t2_css", {31'h0, s_css}, 32'h0);
    chk("t2_mosi", s_mosi, dat_w);
    @(negedge p_clk);
    chk("beat1_sclk", {31'h0, s_clk}, 32'h1);
    chk("beat1_css", {31'h0, s_css}, 32'h0);
    chk("beat1_mosi", s_mosi, dat_w);
    @(negedge p_clk);
    chk("t4_css", {31'h0, s_css}, 32'h1);
    chk("t4_sclk", {31'h0, s_clk}, 32'h0);
    chk("t4_mosi", s_mosi, 32'h0);
    chk("t4_rdata", p_rdata, ref_rdata);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge p_clk);
        chk("no_second_frame", {31'h0, s_css}, 32'h1);
      end
    end
  endtask

  initial begin
    logic [31:0] r, ad;
    p_rst = 1'b1; p_addr = 32'h0; p_write = 1'b0; p_sel_x = 1'b0; p_enable = 1'b0; p_wdata = 32'h0;
    #12;
    chk("rst_css", {31'h0, s_css}, 32'h1);
    chk("rst_sclk", {31'h0, s_clk}, 32'h0);
    chk("rst_mosi", s_mosi, 32'h0);
    chk("rst_rdata", p_rdata, 32'h0);
    @(negedge p_clk);
    p_rst = 1'b0;

    // Setup phase only: no frame may start.
    p_sel_x = 1'b1; p_enable = 1'b0; p_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge p_clk);
      chk("setup_only_css", {31'h0, s_css}, 32'h1);
    end
    p_sel_x = 1'b0;

    apb_access(1'b1, 32'h0000_0000, 32'hFF00FF00, 1'b0);

    // Read aborted by reset just before T2 must leave p_rdata at zero.
    @(negedge p_clk);
    p_sel_x = 1'b1; p_write = 1'b0; p_addr = 32'h0;
    @(negedge p_clk);
    p_enable = 1'b1;
    @(negedge p_clk);
    p_sel_x = 1'b0; p_enable = 1'b0;
    @(negedge p_clk);
    p_rst = 1'b1;
    #1;
    chk("abort_css", {31'h0, s_css}, 32'h1);
    chk("abort_sclk", {31'h0, s_clk}, 32'h0);
    chk("abort_mosi", s_mosi, 32'h0);
    chk("abort_rdata", p_rdata, 32'h0);
    @(negedge p_clk);
    p_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge p_clk);
      chk("post_abort_css", {31'h0, s_css}, 32'h1);
      chk("post_abort_rdata", p_rdata, 32'h0);
    end

    apb_access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    chk("readback_value", ref_rdata, 32'hFF00FF00);
    apb_access(1'b1, 32'hAB12_3456, 32'hCAFE_F00D, 1'b0);
    apb_access(1'b0, 32'h0012_3456, 32'h0, 1'b1);
    apb_access(1'b1, 32'h0000_0003, 32'h1357_9BDF, 1'b1);

    for (int n = 0; n < 30; n++) begin
      r  = $urandom;
      ad = {r[31:24], 22'h0, r[1:0]};
      apb_access(r[8], ad, $urandom, r[9] & r[10]);
      if (r[12]) repeat (r[14:13]) @(negedge p_clk);
    end

    // Make p_rdata non-zero, then check asynchronous clearing between clock edges.
    apb_access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    #2;
    p_rst = 1'b1;
    #1;
    ref_rdata = 32'h0;
    chk("async_rst_rdata", p_rdata, 32'h0);
    chk("async_rst_css", {31'h0, s_css}, 32'h1);
    @(negedge p_clk);
    p_rst = 1'b0;
    apb_access(1'b0, 32'h0000_0003, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_spi_norflash_ctrl.md
Name: apb_spi_norflash_ctrl

Overview:
APB-slave to word-parallel SPI-style master bridge for a NOR flash device. Each completed APB access launches one two-beat flash frame. Beat 0 is a command/address word; beat 1 is a data word (write) or a captured response (read). The block sits between the system APB bus and the external NOR flash pins.

Parameters:
LINEWIDE, 32, width of APB address/data and of s_mosi/s_miso.
CMD_READ, 8'h01, command byte for a flash read.
CMD_WRITE, 8'h02, command byte for a flash write.

Ports:
p_clk  input  1  single clock; all logic on its rising edge.
p_rst  input  1  reset, asynchronous, active-high.
p_addr  input  32  APB address; bits [23:0] are the flash word address.
p_write  input  1  APB direction: 1 = write, 0 = read.
p_sel_x  input  1  APB slave select.
p_enable  input  1  APB access-phase strobe.
p_wdata  input  32  APB write data.
p_rdata  output  32  read-data register.
s_mosi  output  32  word-parallel master-out bus.
s_miso  input  32  word-parallel master-in bus.
s_clk  output  1  flash beat clock; idles low.
s_css  output  1  flash chip select, active-low.

Behaviour:
- Reset (async, p_rst=1): state IDLE, s_css=1, s_clk=0, s_mosi=0, p_rdata=0, internal latches=0.
- There is no PREADY. The APB side is always zero-wait. Setup phase is p_sel_x=1 with p_enable=0. An access is accepted on an edge where p_sel_x=1, p_enable=1 and state is IDLE (call this edge T0).
- At T0, latch p_write, p_addr[23:0] and p_wdata, then drive:
  - s_css <= 0
  - s_mosi <= {p_addr[23:0], cmd}, where cmd = CMD_WRITE if p_write else CMD_READ
  - state <= CMD_LO
- FSM, one transition per p_clk edge:
  - CMD_LO -> CMD_HI: s_clk <= 1 at T1. This is beat 0; the flash samples the command word.
  - CMD_HI -> DAT_LO: s_clk <= 0 at T2. s_mosi <= latched wdata on a write, 0 on a read.
  - DAT_LO -> DAT_HI: s_clk <= 1 at T3. This is beat 1; the flash stores data or drives s_miso.
  - DAT_HI -> IDLE at T4: s_clk <= 0, s_css <= 1, s_mosi <= 0. On a read, p_rdata <= s_miso.
- Frame length: s_css is low for exactly 4 cycles, with exactly 2 s_clk high pulses of 1 cycle each. The s_clk period is 2 p_clk cycles.
- Read latency: p_rdata holds the new data from T4. During the APB read access phase itself, p_rdata still shows the previous read result. Software issues a read, then fetches p_rdata at least 5 cycles later. p_rdata is held until the next read completes; writes never change p_rdata.
- Busy: access-phase edges at T1..T4 (state != IDLE) are ignored and dropped, with no side effects. A new access can be accepted at T5.
- Setup-only cycles (p_enable=0) and cycles with p_sel_x=0 start no frame. A p_enable held high for several cycles starts one frame only at T0; later edges fall in busy and are dropped.
- p_addr[31:24] are ignored.
- Reset asserted mid-frame aborts immediately to the reset values, with s_css high. No partial p_rdata update occurs.

Decomposition:
- Shared package: LINEWIDE, CMD_READ/CMD_WRITE constants, and the FSM state enum (IDLE, CMD_LO, CMD_HI, DAT_LO, DAT_HI).
- One natural sub-module, spi_frame_engine, holding the FSM and the s_* pin drivers. The top holds APB decode, request latching and the p_rdata register.

Test Plan:
- Reset: assert p_rst mid-sim -> s_css=1, s_clk=0, s_mosi=0, p_rdata=0 asynchronously.
- Write: APB write addr 0, wdata 32'hFF00FF00 -> s_mosi=32'h00000002 at beat 0 and 32'hFF00FF00 at beat 1. s_css low 4 cycles, 2 s_clk pulses, p_rdata unchanged.
- Read-back: slave model returns stored word; APB read addr 0 after the write -> s_mosi=32'h00000001 at beat 0, p_rdata=32'hFF00FF00 from T4.
- Address mapping: write to p_addr=32'hAB123456 -> beat-0 word 32'h12345602.
- Busy drop: second access-phase edge at T2 of a frame -> no second frame and no latched change. The next access at T5 or later works.
- Setup-only and reset abort: p_sel_x=1 with p_enable=0 for 3 cycles -> s_css stays 1. Assert p_rst at T2 -> s_css=1 at once, p_rdata stays 0.
